// File: rtl/mult_bcd_conv_if.sv
// Handshake bundle between the multiplier (master) and the BCD conversion stage (slave).
interface mult_bcd_conv_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  done_flag;
   logic [WIDTH-1:0]      product_in;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  bcd_valid;
   logic                  busy;
   logic                  overrun;

   modport master (
      output done_flag,
      output product_in,
      input  bcd_out,
      input  bcd_valid,
      input  busy,
      input  overrun
   );

   modport slave (
      input  done_flag,
      input  product_in,
      output bcd_out,
      output bcd_valid,
      output busy,
      output overrun
   );
endinterface

// File: rtl/mult_bcd_conv.sv
// Captures the multiplier product on a done_flag rise and converts it to packed BCD
// with a one-bit-per-clock shift-add-3 engine.
module mult_bcd_conv #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               ena,
   mult_bcd_conv_if.slave     bus
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      OUT   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]  bin_sr_q, bin_sr_d;
   logic [BW-1:0]     bcd_sr_q, bcd_sr_d;
   logic [BW-1:0]     bcd_out_q, bcd_out_d;
   logic              bcd_valid_q, bcd_valid_d;
   logic              overrun_q, overrun_d;
   logic              done_prev_q;
   logic              rise;
   logic [BW-1:0]     bcd_adj;

   // done_prev resets high so a level already asserted at reset release is not a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bin_sr_q    <= '0;
         bcd_sr_q    <= '0;
         bcd_out_q   <= '0;
         bcd_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         done_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bin_sr_q    <= bin_sr_d;
         bcd_sr_q    <= bcd_sr_d;
         bcd_out_q   <= bcd_out_d;
         bcd_valid_q <= bcd_valid_d;
         overrun_q   <= overrun_d;
         done_prev_q <= bus.done_flag;
      end
   end

   assign rise = bus.done_flag & ~done_prev_q;

   always_comb begin
      state_d = state_q;
      if (ena) begin
         case (state_q)
            IDLE:    if (rise) state_d = SHIFT;
            SHIFT:   if (cnt_q == CW'(WIDTH - 1)) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bcd_adj     = '0;
      cnt_d       = cnt_q;
      bin_sr_d    = bin_sr_q;
      bcd_sr_d    = bcd_sr_q;
      bcd_out_d   = bcd_out_q;
      bcd_valid_d = 1'b0;
      overrun_d   = overrun_q;

      // Each digit is corrected independently; a corrected digit never exceeds 4 bits.
      for (int i = 0; i < DIGITS; i++) begin
         bcd_adj[4*i +: 4] = bcd_sr_q[4*i +: 4] +
                             ((bcd_sr_q[4*i +: 4] >= 4'd5) ? 4'd3 : 4'd0);
      end

      if (ena) begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  bin_sr_d  = bus.product_in;
                  bcd_sr_d  = '0;
                  cnt_d     = '0;
                  overrun_d = 1'b0;
               end
            end
            SHIFT: begin
               {bcd_sr_d, bin_sr_d} = {bcd_adj[BW-2:0], bin_sr_q, 1'b0};
               cnt_d = cnt_q + CW'(1);
               if (rise) overrun_d = 1'b1;
            end
            OUT: begin
               bcd_out_d   = bcd_sr_q;
               bcd_valid_d = 1'b1;
               if (rise) overrun_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.bcd_out   = bcd_out_q;
   assign bus.bcd_valid = bcd_valid_q & ena;
   assign bus.busy      = (state_q != IDLE);
   assign bus.overrun   = overrun_q;

endmodule
